// File: rtl/mem_block_arbiter_pkg.sv
// Shared definitions for the icache/dcache memory-port arbiter:
// FSM states, requester identifiers and default bus widths.
package mem_block_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_block_arbiter_rr.sv
// Two-way round-robin pick between icache and dcache.
// Also owns the last-grant history, which advances only on a grant strobe.
module rr_arb2
  import mem_block_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ic_req,
  input  logic dc_req,
  input  logic grant_en,
  output logic gnt_ic,
  output logic gnt_dc
);

  req_id_t last_grant;

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    gnt_ic = ic_req && (!dc_req || (last_grant == REQ_DC));
    gnt_dc = dc_req && !gnt_ic;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_DC;
    end else if (grant_en && (gnt_ic || gnt_dc)) begin
      last_grant <= gnt_ic ? REQ_IC : REQ_DC;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Shares one line-wide memory port between the icache (reads) and the
// dcache (reads and write-backs); IDLE -> XFER -> RESP per transfer.
module mem_block_arbiter
  import mem_block_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_busy,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state, state_nxt;
  req_id_t    owner;
  logic       gnt_ic, gnt_dc;
  logic       grant, done;
  logic       in_idle;

  assign in_idle = (state == ST_IDLE);

  rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req),
    .dc_req   (dc_req),
    .grant_en (in_idle),
    .gnt_ic   (gnt_ic),
    .gnt_dc   (gnt_dc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (gnt_ic || gnt_dc) state_nxt = ST_XFER;
      ST_XFER: if (mem_ready)        state_nxt = ST_RESP;
      ST_RESP:                       state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Transfer strobes that steer the registered datapath below.
  always_comb begin
    grant = in_idle && (gnt_ic || gnt_dc);
    done  = (state == ST_XFER) && mem_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= REQ_IC;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_busy   <= 1'b0;
      dc_busy   <= 1'b0;
      ic_ack    <= 1'b0;
      dc_ack    <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      ic_ack <= done && (owner == REQ_IC);
      dc_ack <= done && (owner == REQ_DC);

      if (grant) begin
        owner     <= gnt_ic ? REQ_IC : REQ_DC;
        mem_req   <= 1'b1;
        mem_we    <= gnt_dc && dc_we;
        mem_addr  <= gnt_ic ? ic_addr : dc_addr;
        mem_wdata <= gnt_ic ? '0 : dc_wdata;
        ic_busy   <= gnt_dc;
        dc_busy   <= gnt_ic;
      end else if (state == ST_RESP) begin
        ic_busy <= 1'b0;
        dc_busy <= 1'b0;
      end

      if (done) begin
        mem_req <= 1'b0;
        if (owner == REQ_IC)  ic_rdata <= mem_rdata;
        else if (!mem_we)     dc_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter: single transfers, write-back,
// round-robin alternation, reset abort, stray ready and held requests.
module tb_mem_block_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we, mem_ready;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata, mem_rdata;
  logic          ic_ack, ic_busy, dc_ack, dc_busy, mem_req, mem_we;
  logic [LW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  mem_block_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata), .ic_busy(ic_busy),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata), .dc_busy(dc_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked mid-cycle while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("busy_overlap", LW'(ic_busy & dc_busy), '0);
      chk("onehot_req_ack", LW'((32'(mem_req) + 32'(ic_ack) + 32'(dc_ack)) > 1), '0);
    end
  end

  localparam logic [LW-1:0] PAT_A5 = {8{32'hA5A5_A5A5}};
  localparam logic [LW-1:0] PAT_3C = {8{32'h3C3C_3C3C}};
  localparam logic [LW-1:0] PAT_DE = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] PAT_5A = {8{32'h5A5A_5A5A}};
  localparam logic [LW-1:0] PAT_77 = {8{32'h7777_0001}};

  initial begin
    logic          own_dc;
    logic [LW-1:0] pat;

    reset = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", LW'(mem_req), '0);
    chk("rst_acks", LW'({ic_ack, dc_ack}), '0);
    chk("rst_busys", LW'({ic_busy, dc_busy}), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_ic_rdata", ic_rdata, '0);
    reset = 1'b0;
    tick();

    // 1: icache read, ready two cycles after request
    ic_req = 1; ic_addr = 9'h015;
    tick();
    chk("t1_mem_req", LW'(mem_req), 1);
    chk("t1_mem_addr", LW'(mem_addr), LW'(9'h015));
    chk("t1_mem_we", LW'(mem_we), 0);
    chk("t1_dc_busy", LW'(dc_busy), 1);
    chk("t1_ic_busy", LW'(ic_busy), 0);
    tick();
    chk("t1_hold_req", LW'(mem_req), 1);
    chk("t1_no_ack_yet", LW'(ic_ack), 0);
    mem_ready = 1; mem_rdata = PAT_A5;
    tick();
    chk("t1_ic_ack", LW'(ic_ack), 1);
    chk("t1_req_drop", LW'(mem_req), 0);
    chk("t1_ic_rdata", ic_rdata, PAT_A5);
    chk("t1_busy_resp", LW'(dc_busy), 1);
    ic_req = 0; mem_ready = 0;
    tick();
    chk("t1_ack_off", LW'(ic_ack), 0);
    chk("t1_busy_off", LW'(dc_busy), 0);

    // 2: dcache write-back
    dc_req = 1; dc_we = 1; dc_addr = 9'h1F0; dc_wdata = PAT_3C;
    tick();
    chk("t2_mem_we", LW'(mem_we), 1);
    chk("t2_mem_addr", LW'(mem_addr), LW'(9'h1F0));
    chk("t2_mem_wdata", mem_wdata, PAT_3C);
    chk("t2_ic_busy", LW'(ic_busy), 1);
    mem_ready = 1; mem_rdata = PAT_DE;
    tick();
    chk("t2_dc_ack", LW'(dc_ack), 1);
    chk("t2_ic_busy_resp", LW'(ic_busy), 1);
    chk("t2_dc_rdata_kept", dc_rdata, '0);
    dc_req = 0; dc_we = 0; mem_ready = 0;
    tick();
    chk("t2_ack_off", LW'(dc_ack), 0);
    chk("t2_busy_off", LW'(ic_busy), 0);

    // 3: both held after reset -> IC, DC, IC, DC
    reset = 1; tick(); reset = 0;
    ic_addr = 9'h011; dc_addr = 9'h122; dc_we = 0;
    ic_req = 1; dc_req = 1;
    for (int g = 0; g < 4; g++) begin
      own_dc = g[0];
      pat = PAT_77 + LW'(g);
      tick();
      chk($sformatf("t3_g%0d_addr", g), LW'(mem_addr), own_dc ? LW'(9'h122) : LW'(9'h011));
      chk($sformatf("t3_g%0d_ic_busy", g), LW'(ic_busy), LW'(own_dc));
      chk($sformatf("t3_g%0d_dc_busy", g), LW'(dc_busy), LW'(!own_dc));
      mem_ready = 1; mem_rdata = pat;
      tick();
      chk($sformatf("t3_g%0d_acks", g), LW'({ic_ack, dc_ack}), own_dc ? LW'(2'b01) : LW'(2'b10));
      chk($sformatf("t3_g%0d_rdata", g), own_dc ? dc_rdata : ic_rdata, pat);
      mem_ready = 0;
      tick();
    end
    ic_req = 0; dc_req = 0;
    tick();

    // 4: reset during XFER
    ic_req = 1; ic_addr = 9'h0F0;
    tick();
    chk("t4_in_xfer", LW'(mem_req), 1);
    #2 reset = 1;
    #1;
    chk("t4_req_abort", LW'(mem_req), 0);
    chk("t4_busys_abort", LW'({ic_busy, dc_busy}), '0);
    ic_req = 0;
    tick();
    chk("t4_no_ack", LW'({ic_ack, dc_ack}), '0);
    reset = 0;
    tick();
    ic_req = 1; ic_addr = 9'h0AA;
    tick();
    chk("t4_regrant_addr", LW'(mem_addr), LW'(9'h0AA));
    chk("t4_regrant_busy", LW'(dc_busy), 1);
    mem_ready = 1; mem_rdata = PAT_5A;
    tick();
    chk("t4_regrant_ack", LW'(ic_ack), 1);
    ic_req = 0; mem_ready = 0;
    tick();

    // 5: stray ready in IDLE, then 1-cycle dcache read
    mem_ready = 1; mem_rdata = PAT_DE;
    tick(); tick();
    chk("t5_stray_req", LW'(mem_req), 0);
    chk("t5_stray_ack", LW'({ic_ack, dc_ack}), '0);
    mem_ready = 0;
    dc_req = 1; dc_we = 0; dc_addr = 9'h000;
    tick();
    chk("t5_mem_addr", LW'(mem_addr), '0);
    chk("t5_mem_we", LW'(mem_we), 0);
    chk("t5_ic_busy", LW'(ic_busy), 1);
    mem_ready = 1; mem_rdata = PAT_3C;
    tick();
    chk("t5_dc_ack", LW'(dc_ack), 1);
    chk("t5_dc_rdata", dc_rdata, PAT_3C);
    dc_req = 0; mem_ready = 0;
    tick();
    chk("t5_ack_once_a", LW'(dc_ack), 0);
    tick();
    chk("t5_ack_once_b", LW'(dc_ack), 0);
    chk("t5_idle", LW'(mem_req), 0);

    // 6: req held through the ack cycle, dropped on the edge leaving RESP
    ic_req = 1; ic_addr = 9'h033;
    tick();
    mem_ready = 1; mem_rdata = PAT_A5;
    tick();
    chk("t6_ack", LW'(ic_ack), 1);
    mem_ready = 0;
    tick();
    chk("t6_ack_off", LW'(ic_ack), 0);
    chk("t6_no_regrant_a", LW'(mem_req), 0);
    ic_req = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_no_regrant_%0d", k), LW'({mem_req, ic_ack, dc_busy}), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
